// File: rtl/fft_frame_feeder_pkg.sv
// fft_frame_feeder_pkg: feeder state encoding, frame length and FIFO entry width helpers
package fft_frame_feeder_pkg;
  typedef enum logic [2:0] {CFG_LOAD, CFG, IDLE, FILL, PAD, DRAIN} state_t;
  localparam int FIFO_ENTRY_W = 33;
  function automatic int fft_len(input int log2);
    return 1 << log2;
  endfunction
  function automatic int entry_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/fft_sample_fifo.sv
// fft_sample_fifo: FWFT skid FIFO (clk_245, async clk_245_rst; push/din in, pop/dout/full/empty out; push accepted at full when popping)
module fft_sample_fifo #(
  parameter int W  = 33,
  parameter int DL = 4
) (
  input  logic         clk_245,
  input  logic         clk_245_rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam logic [DL:0] ONE = (DL+1)'(1);
  logic [W-1:0] mem [2**DL];
  logic [DL:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = wp == rp;
    full = (wp[DL] != rp[DL]) && (wp[DL-1:0] == rp[DL-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rp[DL-1:0]];
  end
  always_ff @(posedge clk_245 or posedge clk_245_rst)
    if (clk_245_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + ONE;
      if (do_pop) rp <= rp + ONE;
    end
  always_ff @(posedge clk_245)
    if (do_push) mem[wp[DL-1:0]] <= din;
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: frames gated {I,Q} samples for the FFT (adc_* in, s_axis_config_*/s_axis_data_* AXIS out, frame/drop counters, overflow, busy)
module fft_frame_feeder
  import fft_frame_feeder_pkg::*;
#(
  parameter int FFT_LEN_LOG2    = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int CONFIG_WIDTH    = 24,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                    clk_245,
  input  logic                    clk_245_rst,
  input  logic                    adc_enable,
  input  logic [DATA_WIDTH-1:0]   adc_data_iq,
  input  logic                    adc_data_valid,
  input  logic [CONFIG_WIDTH-1:0] fft_config_word,
  input  logic                    fft_config_update,
  output logic [CONFIG_WIDTH-1:0] s_axis_config_tdata,
  output logic                    s_axis_config_tvalid,
  input  logic                    s_axis_config_tready,
  output logic [DATA_WIDTH-1:0]   s_axis_data_tdata,
  output logic                    s_axis_data_tvalid,
  input  logic                    s_axis_data_tready,
  output logic                    s_axis_data_tlast,
  output logic [31:0]             frame_count,
  output logic [15:0]             drop_count,
  output logic                    overflow,
  output logic                    busy
);
  localparam int EW = entry_w(DATA_WIDTH);
  localparam logic [FFT_LEN_LOG2-1:0] LAST = FFT_LEN_LOG2'(fft_len(FFT_LEN_LOG2) - 1);
  localparam logic [FFT_LEN_LOG2-1:0] ONE = FFT_LEN_LOG2'(1);
  state_t state, nxt;
  logic [FFT_LEN_LOG2-1:0] idx;
  logic prev_en, pending, push, pop, acc, drop, last, full, empty, cfg_hs;
  logic [EW-1:0] din, dout;
  fft_sample_fifo #(.W(EW), .DL(FIFO_DEPTH_LOG2)) u_fifo (
    .clk_245(clk_245),
    .clk_245_rst(clk_245_rst),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  assign {s_axis_data_tlast, s_axis_data_tdata} = dout;
  assign s_axis_data_tvalid = !empty;
  always_comb begin
    last = idx == LAST;
    pop = !empty && s_axis_data_tready;
    push = (state == FILL && adc_enable && adc_data_valid) || state == PAD;
    din = {last, adc_data_iq & {DATA_WIDTH{state == FILL}}};
    acc = push && (!full || pop);
    drop = state == FILL && push && !acc;
    cfg_hs = state == CFG && s_axis_config_tready;
    nxt = state;
    case (state)
      CFG_LOAD: nxt = CFG;
      CFG:      nxt = s_axis_config_tready ? IDLE : CFG;
      IDLE:     nxt = (pending || fft_config_update) ? CFG_LOAD : (adc_enable && !prev_en) ? FILL : IDLE;
      FILL:     nxt = adc_enable ? FILL : (idx == '0) ? DRAIN : PAD;
      PAD:      nxt = (acc && last) ? DRAIN : PAD;
      DRAIN:    nxt = empty ? (pending ? CFG_LOAD : IDLE) : DRAIN;
      default:  nxt = CFG_LOAD;
    endcase
  end
  always_ff @(posedge clk_245 or posedge clk_245_rst)
    if (clk_245_rst) begin
      state <= CFG_LOAD;
      idx <= '0;
      prev_en <= 1'b0;
      pending <= 1'b0;
      s_axis_config_tdata <= '0;
      s_axis_config_tvalid <= 1'b0;
      frame_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      prev_en <= adc_enable;
      busy <= nxt != IDLE;
      if (state == CFG_LOAD) begin
        s_axis_config_tdata <= fft_config_word;
        s_axis_config_tvalid <= 1'b1;
      end else if (cfg_hs) s_axis_config_tvalid <= 1'b0;
      pending <= cfg_hs ? 1'b0 : (fft_config_update && state inside {FILL, PAD, DRAIN}) ? 1'b1 : pending;
      idx <= (state == IDLE) ? '0 : acc ? idx + ONE : idx;
      if (pop && s_axis_data_tlast) frame_count <= frame_count + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed self-checking bench for fft_frame_feeder with 8-sample frames
module tb_fft_frame_feeder;
  logic clk_245 = 1'b0;
  logic clk_245_rst = 1'b1;
  logic adc_enable = 1'b0;
  logic [31:0] adc_data_iq = '0;
  logic adc_data_valid = 1'b0;
  logic [23:0] fft_config_word = 24'h000A5C;
  logic fft_config_update = 1'b0;
  logic [23:0] s_axis_config_tdata;
  logic s_axis_config_tvalid;
  logic s_axis_config_tready = 1'b0;
  logic [31:0] s_axis_data_tdata;
  logic s_axis_data_tvalid;
  logic s_axis_data_tready = 1'b0;
  logic s_axis_data_tlast;
  logic [31:0] frame_count;
  logic [15:0] drop_count;
  logic overflow;
  logic busy;
  int errors = 0;
  int checks = 0;
  int cfg_hs = 0;
  logic [32:0] q[$];

  fft_frame_feeder #(.FFT_LEN_LOG2(3), .DATA_WIDTH(32), .CONFIG_WIDTH(24), .FIFO_DEPTH_LOG2(4)) dut (
    .clk_245(clk_245),
    .clk_245_rst(clk_245_rst),
    .adc_enable(adc_enable),
    .adc_data_iq(adc_data_iq),
    .adc_data_valid(adc_data_valid),
    .fft_config_word(fft_config_word),
    .fft_config_update(fft_config_update),
    .s_axis_config_tdata(s_axis_config_tdata),
    .s_axis_config_tvalid(s_axis_config_tvalid),
    .s_axis_config_tready(s_axis_config_tready),
    .s_axis_data_tdata(s_axis_data_tdata),
    .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tready(s_axis_data_tready),
    .s_axis_data_tlast(s_axis_data_tlast),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .overflow(overflow),
    .busy(busy)
  );

  always #2 clk_245 = ~clk_245;

  always @(negedge clk_245) begin
    if (s_axis_data_tvalid && s_axis_data_tready) q.push_back({s_axis_data_tlast, s_axis_data_tdata});
    if (s_axis_config_tvalid && s_axis_config_tready) cfg_hs++;
  end

  task automatic tick;
    @(posedge clk_245);
    #1;
  endtask

  task automatic arm;
    tick;
    adc_enable = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_reset;
    @(negedge clk_245);
    checks++; if (s_axis_data_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", s_axis_data_tvalid); end
    checks++; if (s_axis_config_tvalid !== 1'b0) begin errors++; $display("FAIL reset_cfg_tvalid got %b want 0", s_axis_config_tvalid); end
    checks++; if (s_axis_config_tdata !== 24'h0) begin errors++; $display("FAIL reset_cfg_tdata got %h want 000000", s_axis_config_tdata); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_config;
    int n;
    tick;
    clk_245_rst = 1'b0;
    n = 0;
    @(negedge clk_245);
    while (!s_axis_config_tvalid && n < 20) begin
      @(negedge clk_245);
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL cfg_timeout got %0d cycles want <20", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_axis_config_tvalid !== 1'b1 || cfg_hs != 0) begin errors++; $display("FAIL cfg_hold[%0d] got tvalid=%b hs=%0d want 1/0", i, s_axis_config_tvalid, cfg_hs); end
      @(negedge clk_245);
    end
    tick;
    s_axis_config_tready = 1'b1;
    tick;
    s_axis_config_tready = 1'b0;
    repeat (3) tick;
    @(negedge clk_245);
    checks++; if (cfg_hs != 1) begin errors++; $display("FAIL cfg_handshakes got %0d want 1", cfg_hs); end
    checks++; if (s_axis_config_tdata !== 24'h000A5C) begin errors++; $display("FAIL cfg_tdata got %h want 000a5c", s_axis_config_tdata); end
    checks++; if (s_axis_config_tvalid !== 1'b0) begin errors++; $display("FAIL cfg_tvalid_after got %b want 0", s_axis_config_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy_after got %b want 0", busy); end
  endtask

  task automatic test_single_frame;
    logic [31:0] fc0;
    fc0 = frame_count;
    s_axis_data_tready = 1'b1;
    arm;
    for (int i = 1; i <= 8; i++) begin
      tick;
      adc_data_iq = 32'(i);
      adc_data_valid = 1'b1;
      @(negedge clk_245);
      if (i == 1) begin
        checks++; if (s_axis_data_tvalid !== 1'b0) begin errors++; $display("FAIL frame_early_tvalid got %b want 0", s_axis_data_tvalid); end
      end else begin
        checks++; if (s_axis_data_tvalid !== 1'b1 || s_axis_data_tdata !== 32'(i - 1) || s_axis_data_tlast !== 1'b0) begin
          errors++; $display("FAIL frame_beat[%0d] got v=%b d=%0d l=%b want 1/%0d/0", i - 1, s_axis_data_tvalid, s_axis_data_tdata, s_axis_data_tlast, i - 1);
        end
      end
    end
    tick;
    adc_enable = 1'b0;
    adc_data_valid = 1'b0;
    @(negedge clk_245);
    checks++; if (s_axis_data_tvalid !== 1'b1 || s_axis_data_tdata !== 32'd8 || s_axis_data_tlast !== 1'b1) begin
      errors++; $display("FAIL frame_last got v=%b d=%0d l=%b want 1/8/1", s_axis_data_tvalid, s_axis_data_tdata, s_axis_data_tlast);
    end
    repeat (3) tick;
    @(negedge clk_245);
    checks++; if (frame_count !== fc0 + 32'd1) begin errors++; $display("FAIL frame_count got %0d want %0d", frame_count, fc0 + 32'd1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy got %b want 0", busy); end
  endtask

  task automatic test_pad;
    logic [31:0] fc0;
    logic [32:0] e;
    int n;
    fc0 = frame_count;
    q.delete();
    arm;
    for (int i = 1; i <= 5; i++) begin
      tick;
      adc_data_iq = 32'(i);
      adc_data_valid = 1'b1;
    end
    tick;
    adc_enable = 1'b0;
    adc_data_valid = 1'b0;
    n = 0;
    while (q.size() < 8 && n < 40) begin
      @(negedge clk_245);
      n++;
    end
    repeat (4) tick;
    @(negedge clk_245);
    checks++; if (q.size() != 8) begin errors++; $display("FAIL pad_beats got %0d want 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      e = {i == 7, (i < 5) ? 32'(i + 1) : 32'd0};
      checks++; if (q[i] !== e) begin errors++; $display("FAIL pad_beat[%0d] got %h want %h", i, q[i], e); end
    end
    checks++; if (frame_count !== fc0 + 32'd1) begin errors++; $display("FAIL pad_frame_count got %0d want %0d", frame_count, fc0 + 32'd1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pad_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] fc0;
    logic [32:0] e;
    int n;
    fc0 = frame_count;
    q.delete();
    s_axis_data_tready = 1'b0;
    arm;
    for (int i = 1; i <= 20; i++) begin
      tick;
      adc_data_iq = 32'(i);
      adc_data_valid = 1'b1;
    end
    tick;
    adc_enable = 1'b0;
    adc_data_valid = 1'b0;
    repeat (3) tick;
    @(negedge clk_245);
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL bp_drop_count got %0d want 4", drop_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow); end
    checks++; if (s_axis_data_tvalid !== 1'b1 || q.size() != 0) begin errors++; $display("FAIL bp_held got v=%b beats=%0d want 1/0", s_axis_data_tvalid, q.size()); end
    tick;
    s_axis_data_tready = 1'b1;
    n = 0;
    while (q.size() < 16 && n < 60) begin
      @(negedge clk_245);
      n++;
    end
    repeat (4) tick;
    @(negedge clk_245);
    checks++; if (q.size() != 16) begin errors++; $display("FAIL bp_beats got %0d want 16", q.size()); end
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      e = {i == 7 || i == 15, 32'(i + 1)};
      checks++; if (q[i] !== e) begin errors++; $display("FAIL bp_beat[%0d] got %h want %h", i, q[i], e); end
    end
    checks++; if (frame_count !== fc0 + 32'd2) begin errors++; $display("FAIL bp_frame_count got %0d want %0d", frame_count, fc0 + 32'd2); end
  endtask

  task automatic test_config_mid_frame;
    int h0;
    h0 = cfg_hs;
    s_axis_config_tready = 1'b1;
    arm;
    for (int i = 1; i <= 8; i++) begin
      tick;
      adc_data_iq = 32'(i + 100);
      adc_data_valid = 1'b1;
      fft_config_update = i == 3;
    end
    tick;
    adc_enable = 1'b0;
    adc_data_valid = 1'b0;
    @(negedge clk_245);
    checks++; if (s_axis_data_tlast !== 1'b1 || s_axis_data_tdata !== 32'd108) begin errors++; $display("FAIL mid_last got d=%0d l=%b want 108/1", s_axis_data_tdata, s_axis_data_tlast); end
    checks++; if (cfg_hs != h0 || s_axis_config_tvalid !== 1'b0) begin errors++; $display("FAIL mid_early_cfg got hs=%0d v=%b want %0d/0", cfg_hs, s_axis_config_tvalid, h0); end
    repeat (10) tick;
    @(negedge clk_245);
    checks++; if (cfg_hs != h0 + 1) begin errors++; $display("FAIL mid_cfg_count got %0d want %0d", cfg_hs, h0 + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int h0;
    int tl;
    q.delete();
    arm;
    for (int i = 1; i <= 3; i++) begin
      tick;
      adc_data_iq = 32'(i);
      adc_data_valid = 1'b1;
    end
    tick;
    clk_245_rst = 1'b1;
    adc_enable = 1'b0;
    adc_data_valid = 1'b0;
    #1;
    checks++; if (s_axis_data_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", s_axis_data_tvalid); end
    checks++; if (frame_count !== 32'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL rst_counters got fc=%0d dc=%0d want 0/0", frame_count, drop_count); end
    checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flags got ovf=%b busy=%b want 0/0", overflow, busy); end
    repeat (2) tick;
    h0 = cfg_hs;
    clk_245_rst = 1'b0;
    repeat (10) tick;
    @(negedge clk_245);
    tl = 0;
    foreach (q[i]) if (q[i][32]) tl++;
    checks++; if (q.size() != 2 || tl != 0) begin errors++; $display("FAIL rst_beats got n=%0d tlast=%0d want 2/0", q.size(), tl); end
    checks++; if (cfg_hs != h0 + 1) begin errors++; $display("FAIL rst_cfg_resend got %0d want %0d", cfg_hs, h0 + 1); end
    checks++; if (s_axis_config_tdata !== 24'h000A5C) begin errors++; $display("FAIL rst_cfg_tdata got %h want 000a5c", s_axis_config_tdata); end
  endtask

  initial begin
    test_reset;
    test_config;
    test_single_frame;
    test_pad;
    test_back_to_back;
    test_config_mid_frame;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
